// File: rtl/tx_packet_serializer.sv
// Purpose: captures rewardv2 packet fields and streams them as 16-bit words to the radio once the MAC grants a slot.
// Latency: first txValid one cycle after okToSend is sampled; 8 words (9 with TX_CHECKSUM_EN) plus one DONE cycle.
// Backpressure: txData/txLast held stable while txReady=0; a new strobe while busy is dropped and flagged on overrun.
module tx_packet_serializer #(
    parameter int                WORD_WIDTH  = 16,
    parameter logic [WORD_WIDTH-1:0] NEAR_TX_NRG = 16'h0005,
    parameter logic [WORD_WIDTH-1:0] FAR_TX_NRG  = 16'h001b
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  reward_done,
    input  logic                  tx_setting,
    input  logic [2:0]            rPacketType,
    input  logic [5:0]            rTimeslot,
    input  logic [WORD_WIDTH-1:0] rSourceID,
    input  logic [WORD_WIDTH-1:0] rDestinationID,
    input  logic [WORD_WIDTH-1:0] rSourceHops,
    input  logic [WORD_WIDTH-1:0] rQValue,
    input  logic [WORD_WIDTH-1:0] rEnergyLeft,
    input  logic [WORD_WIDTH-1:0] rChosenCH,
    input  logic [WORD_WIDTH-1:0] rHopsFromCH,
    input  logic                  okToSend,
    input  logic                  txReady,
    output logic [WORD_WIDTH-1:0] txData,
    output logic                  txValid,
    output logic                  txLast,
    output logic                  txBusy,
    output logic                  txDone,
    output logic [WORD_WIDTH-1:0] txEnergyCost,
    output logic                  overrun
);

`ifdef TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd8;
`else
    localparam logic [3:0] LAST_IDX = 4'd7;
`endif

    typedef enum logic [1:0] {IDLE, LOADED, SEND, DONE} state_t;

    state_t                state, nextState;
    logic [3:0]            idx, nextIdx;
    logic                  capture;
    logic [WORD_WIDTH-1:0] nextWord;

    logic [2:0]            hPacketType;
    logic [5:0]            hTimeslot;
    logic [WORD_WIDTH-1:0] hSourceID, hDestinationID, hSourceHops, hQValue;
    logic [WORD_WIDTH-1:0] hEnergyLeft, hChosenCH, hHopsFromCH;
    logic                  hTxSetting;
    logic [WORD_WIDTH-1:0] word0;

    assign word0 = {hPacketType, 7'b0, hTimeslot};

`ifdef TX_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] checksum;
    assign checksum = word0 ^ hSourceID ^ hDestinationID ^ hSourceHops ^ hQValue
                    ^ hEnergyLeft ^ hChosenCH ^ hHopsFromCH;
`endif

    // State and word index registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            idx   <= 4'd0;
        end else begin
            state <= nextState;
            idx   <= nextIdx;
        end
    end

    // Next-state logic; the handshake uses state==SEND since txValid mirrors it.
    always_comb begin
        nextState = state;
        nextIdx   = idx;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (reward_done) begin
                    capture   = 1'b1;
                    nextState = LOADED;
                end
            end
            LOADED: begin
                if (okToSend) begin
                    nextState = SEND;
                    nextIdx   = 4'd0;
                end
            end
            SEND: begin
                if (txReady) begin
                    if (idx == LAST_IDX) nextState = DONE;
                    else                 nextIdx   = idx + 4'd1;
                end
            end
            DONE: begin
                nextState = IDLE;
                nextIdx   = 4'd0;
            end
            default: begin
                nextState = IDLE;
                nextIdx   = 4'd0;
            end
        endcase
    end

    // Captured packet fields; only written on the IDLE strobe so they stay frozen until DONE.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hPacketType    <= '0;
            hTimeslot      <= '0;
            hSourceID      <= '0;
            hDestinationID <= '0;
            hSourceHops    <= '0;
            hQValue        <= '0;
            hEnergyLeft    <= '0;
            hChosenCH      <= '0;
            hHopsFromCH    <= '0;
            hTxSetting     <= 1'b0;
        end else if (capture) begin
            hPacketType    <= rPacketType;
            hTimeslot      <= rTimeslot;
            hSourceID      <= rSourceID;
            hDestinationID <= rDestinationID;
            hSourceHops    <= rSourceHops;
            hQValue        <= rQValue;
            hEnergyLeft    <= rEnergyLeft;
            hChosenCH      <= rChosenCH;
            hHopsFromCH    <= rHopsFromCH;
            hTxSetting     <= tx_setting;
        end
    end

    // Word selected by the index that will be current next cycle.
    always_comb begin
        nextWord = '0;
        case (nextIdx)
            4'd0: nextWord = word0;
            4'd1: nextWord = hSourceID;
            4'd2: nextWord = hDestinationID;
            4'd3: nextWord = hSourceHops;
            4'd4: nextWord = hQValue;
            4'd5: nextWord = hEnergyLeft;
            4'd6: nextWord = hChosenCH;
            4'd7: nextWord = hHopsFromCH;
`ifdef TX_CHECKSUM_EN
            4'd8: nextWord = checksum;
`endif
            default: nextWord = '0;
        endcase
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            txData       <= '0;
            txValid      <= 1'b0;
            txLast       <= 1'b0;
            txBusy       <= 1'b0;
            txDone       <= 1'b0;
            txEnergyCost <= '0;
            overrun      <= 1'b0;
        end else begin
            txValid      <= (nextState == SEND);
            txLast       <= (nextState == SEND) && (nextIdx == LAST_IDX);
            txData       <= (nextState == SEND) ? nextWord : '0;
            txBusy       <= (nextState != IDLE);
            txDone       <= (nextState == DONE);
            txEnergyCost <= (nextState == DONE) ? (hTxSetting ? FAR_TX_NRG : NEAR_TX_NRG) : '0;
            overrun      <= reward_done && (state != IDLE);
        end
    end

endmodule

// File: tb/tb_tx_packet_serializer.sv
// Purpose: randomized bench for tx_packet_serializer against a word-list reference model.
// Latency: model expects first word one cycle after okToSend, txDone right after the last accepted word.
// Backpressure: txReady driven constant, 1-0-0 pattern or random; stalled words must repeat unchanged.
module tb_tx_packet_serializer;

`ifdef TX_CHECKSUM_EN
    localparam int NWORDS = 9;
`else
    localparam int NWORDS = 8;
`endif

    logic        clk = 1'b0;
    logic        nrst;
    logic        reward_done, tx_setting;
    logic [2:0]  rPacketType;
    logic [5:0]  rTimeslot;
    logic [15:0] rSourceID, rDestinationID, rSourceHops, rQValue;
    logic [15:0] rEnergyLeft, rChosenCH, rHopsFromCH;
    logic        okToSend, txReady;
    logic [15:0] txData, txEnergyCost;
    logic        txValid, txLast, txBusy, txDone, overrun;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  pType;
        logic [5:0]  slot;
        logic [15:0] f [7];   // src, dst, srcHops, q, energy, ch, hopsCh
        logic        txs;
    } pkt_t;

    tx_packet_serializer dut (
        .clk(clk), .nrst(nrst), .reward_done(reward_done), .tx_setting(tx_setting),
        .rPacketType(rPacketType), .rTimeslot(rTimeslot), .rSourceID(rSourceID),
        .rDestinationID(rDestinationID), .rSourceHops(rSourceHops), .rQValue(rQValue),
        .rEnergyLeft(rEnergyLeft), .rChosenCH(rChosenCH), .rHopsFromCH(rHopsFromCH),
        .okToSend(okToSend), .txReady(txReady), .txData(txData), .txValid(txValid),
        .txLast(txLast), .txBusy(txBusy), .txDone(txDone), .txEnergyCost(txEnergyCost),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pkt_t randPkt();
        pkt_t p;
        p.pType = 3'($urandom);
        p.slot  = 6'($urandom);
        for (int i = 0; i < 7; i++) p.f[i] = 16'($urandom);
        p.txs = 1'($urandom);
        return p;
    endfunction

    task automatic driveFields(input pkt_t p);
        rPacketType    = p.pType;
        rTimeslot      = p.slot;
        rSourceID      = p.f[0];
        rDestinationID = p.f[1];
        rSourceHops    = p.f[2];
        rQValue        = p.f[3];
        rEnergyLeft    = p.f[4];
        rChosenCH      = p.f[5];
        rHopsFromCH    = p.f[6];
        tx_setting     = p.txs;
    endtask

    // Reference: packet as a list of words; optional trailing XOR of all previous words.
    function automatic logic [15:0] expWord(input pkt_t p, input int n);
        logic [15:0] w [9];
        w[0] = {p.pType, 7'b0, p.slot};
        for (int i = 0; i < 7; i++) w[i+1] = p.f[i];
        w[8] = 16'h0000;
        for (int i = 0; i < 8; i++) w[8] = w[8] ^ w[i];
        return w[n];
    endfunction

    task automatic runPacket(input pkt_t p, input int readyMode, input bit ovLoaded, input bit ovDone);
        int n;
        int cyc;
        bit r;
        pkt_t q;
        @(negedge clk);
        driveFields(p);
        reward_done = 1'b1;
        @(negedge clk);
        reward_done = 1'b0;
        checkVal("busyLoaded", txBusy, 1);
        checkVal("validLoaded", txValid, 0);
        if (ovLoaded) begin
            q = randPkt();
            q.f[0] = ~p.f[0];
            q.txs = ~p.txs;
            driveFields(q);
            reward_done = 1'b1;
            @(negedge clk);
            reward_done = 1'b0;
            checkVal("overrunPulse", overrun, 1);
            @(negedge clk);
            checkVal("overrunClear", overrun, 0);
        end else begin
            driveFields(randPkt());
        end
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            checkVal("validWaitLoaded", txValid, 0);
        end
        okToSend = 1'b1;
        @(negedge clk);
        okToSend = 1'b0;
        checkVal("firstValidLatency", txValid, 1);
        n = 0;
        cyc = 0;
        while (n < NWORDS && cyc < 200) begin
            checkVal("validInSend", txValid, 1);
            checkVal($sformatf("word%0d", n), txData, expWord(p, n));
            checkVal($sformatf("last%0d", n), txLast, (n == NWORDS - 1));
            checkVal("costInSend", txEnergyCost, 0);
            checkVal("doneInSend", txDone, 0);
            case (readyMode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom);
            endcase
            txReady = r;
            if (r) n++;
            driveFields(randPkt());
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) checkVal("sendTimeout", 0, 1);
        txReady = 1'($urandom);
        checkVal("donePulse", txDone, 1);
        checkVal("energyCost", txEnergyCost, p.txs ? 16'h001b : 16'h0005);
        checkVal("validInDone", txValid, 0);
        checkVal("busyInDone", txBusy, 1);
        if (ovDone) reward_done = 1'b1;
        @(negedge clk);
        reward_done = 1'b0;
        checkVal("doneClear", txDone, 0);
        checkVal("costClear", txEnergyCost, 0);
        checkVal("busyIdle", txBusy, 0);
        checkVal("overrunAfterDone", overrun, ovDone);
        okToSend = 1'b1;
        @(negedge clk);
        okToSend = 1'b0;
        checkVal("okIgnoredIdleBusy", txBusy, 0);
        checkVal("okIgnoredIdleValid", txValid, 0);
    endtask

    initial begin
        pkt_t p;
        nrst = 1'b0;
        reward_done = 1'b0;
        okToSend = 1'b0;
        txReady = 1'b0;
        driveFields(randPkt());
        #1;
        checkVal("rstValid", txValid, 0);
        checkVal("rstBusy", txBusy, 0);
        checkVal("rstData", txData, 0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // Directed basic packet.
        p = randPkt();
        p.pType = 3'b010;
        p.slot  = 6'd5;
        p.f[0]  = 16'd12;
        p.txs   = 1'b0;
        runPacket(p, 0, 0, 0);
        p.txs = 1'b1;
        runPacket(p, 1, 0, 0);

        // All-ones packet exercises the checksum word when enabled.
        p.pType = 3'b111;
        p.slot  = 6'h3f;
        for (int i = 0; i < 7; i++) p.f[i] = 16'hffff;
        runPacket(p, 0, 0, 0);

        runPacket(randPkt(), 0, 1, 0);
        runPacket(randPkt(), 2, 0, 1);
        for (int k = 0; k < 12; k++)
            runPacket(randPkt(), $urandom_range(0, 2), 1'($urandom), 1'($urandom));

        // Reset in the middle of a packet aborts it.
        p = randPkt();
        @(negedge clk);
        driveFields(p);
        reward_done = 1'b1;
        @(negedge clk);
        reward_done = 1'b0;
        okToSend = 1'b1;
        @(negedge clk);
        okToSend = 1'b0;
        txReady = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("preResetValid", txValid, 1);
        nrst = 1'b0;
        #1;
        checkVal("midRstValid", txValid, 0);
        checkVal("midRstData", txData, 0);
        checkVal("midRstLast", txLast, 0);
        checkVal("midRstBusy", txBusy, 0);
        checkVal("midRstDone", txDone, 0);
        checkVal("midRstCost", txEnergyCost, 0);
        checkVal("midRstOverrun", overrun, 0);
        @(negedge clk);
        nrst = 1'b1;
        okToSend = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkVal("postRstBusy", txBusy, 0);
            checkVal("postRstValid", txValid, 0);
        end
        okToSend = 1'b0;

        // Normal operation resumes after the aborted packet.
        runPacket(randPkt(), 2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
